key_extract_param: RTL and testbench
====================================

# key_extract_param

Parametrised key extractor for one RMT match stage. It takes a PHV and looks up a per-stage offset/mask/compare entry, indexed by a table-select field in the PHV metadata. From that entry it builds the lookup key: KEY_N container selections per width class, plus one comparator result bit, with the key masked per entry. It sits between the parser (or the previous stage's action engine) and the stage's lookup engine, and forwards the PHV unchanged alongside the key.

## Interface
- C_NUM, 8: containers per width class (6 B, 4 B, 2 B)
- IDX_W, 3: container index width, clog2(C_NUM)
- KEY_N, 2: containers extracted per width class
- META_LEN, 256: metadata bits at the PHV LSB end
- TBL_DEPTH, 32: offset-table entries
- TBL_AW, 5: table address width
- PHV_LEN, C_NUM*96+META_LEN (1024)
- KEY_LEN, KEY_N*96+1 (193)
- ENT_LEN, 3*KEY_N*IDX_W+2+2*IDX_W+KEY_LEN (219)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- phv_in  in  PHV_LEN  input PHV
- phv_valid_in  in  1  PHV qualifier, one-cycle pulse per PHV
- cfg_wr_en  in  1  table write strobe
- cfg_addr  in  TBL_AW  table write address
- cfg_data  in  ENT_LEN  table write data
- phv_out  out  PHV_LEN  PHV, delayed
- phv_valid_out  out  1  PHV qualifier
- key_out  out  KEY_LEN  masked key
- key_valid_out  out  1  key qualifier, always equal to phv_valid_out

## Operation
- PHV layout, MSB first:
  - C_NUM 48-bit containers, index C_NUM-1 at the top;
  - then C_NUM 32-bit containers;
  - then C_NUM 16-bit containers;
  - then metadata.
- Table address is phv_in[TBL_AW-1:0], the metadata LSBs.
- Entry layout, MSB first:
  - KEY_N 6 B indices, field 0 most significant;
  - KEY_N 4 B indices;
  - KEY_N 2 B indices;
  - cmp_op[1:0], cmp_a[IDX_W], cmp_b[IDX_W];
  - mask[KEY_LEN].
- Key layout, MSB first: {6 B selections, 4 B selections, 2 B selections, cmp_bit}, each group ordered field 0 first.
- Comparator operands are A = 4 B container[cmp_a] and B = 4 B container[cmp_b], unsigned. cmp_op gives cmp_bit:
  - 00: cmp_bit = 0;
  - 01: cmp_bit = (A==B);
  - 10: cmp_bit = (A>B);
  - 11: cmp_bit = (A>=B).
- key_out = raw key AND mask.
- The table is flop-based, with one write port and one read port.
- Writes take effect at the clk edge where cfg_wr_en=1.
- cfg_addr >= TBL_DEPTH: the write is ignored.
- PHV address >= TBL_DEPTH: an all-zero entry is used, so key_out = 0.
- When phv_valid_in=0, the data path may toggle, but the valid outputs stay 0.
- No backpressure; a new PHV is accepted every cycle.

## Timing
- Pipeline stage 1 (edge T+1): register the PHV and valid; read the entry addressed by phv_in at edge T+1.
- Pipeline stage 2 (edge T+2): container mux, compare and mask; register key_out, phv_out and both valids.
- Latency is 2 cycles: PHV presented in cycle T appears on the outputs in cycle T+2. Throughput is 1 PHV per clk.
- Write/lookup collision: a write and a lookup to the same address in the same cycle T → the lookup uses the OLD entry. A lookup in cycle T+1 uses the new entry.
- Reset, asynchronous and active-high, forces:
  - all table entries = 0;
  - phv_out = 0, key_out = 0;
  - phv_valid_out = 0, key_valid_out = 0;
  - all pipeline valids = 0.
- Reset asserted mid-stream discards in-flight PHVs; no valid is emitted for them after deassertion.
- First PHV accepted after reset deassertion: presented in cycle D produces its output in cycle D+2.
- Back-to-back PHVs with different table addresses each use their own entry; there is no cross-contamination between consecutive cycles.

## Test plan
- **Reset values:** assert rst with phv_valid_in=1 → phv_valid_out=0, key_valid_out=0, key_out=0 throughout, and for 2 cycles after release.
- **Container swap:** write entry 0 with 6 B/4 B/2 B indices {6,7} in each class and mask all-ones. Send a PHV with:
  - 6 B[7]=ffffffffffff, 6 B[6]=eeeeeeeeeeee;
  - 4 B[7]=cccccccc, 4 B[6]=bbbbbbbb;
  - 2 B[7]=ffff, 2 B[6]=eeee;
  - metadata=0.
  - → 2 cycles later key_out = {eeeeeeeeeeee, ffffffffffff, bbbbbbbb, cccccccc, eeee, ffff, 0} and phv_out = phv_in.
- **Comparator:** cmp_a=7, cmp_b=6 with 4 B[7]=cccccccc, 4 B[6]=bbbbbbbb:
  - op=10 → cmp_bit=1;
  - op=01 → cmp_bit=0;
  - op=11 with equal operands → cmp_bit=1;
  - op=00 → cmp_bit=0.
- **Mask and table select:** entry 3 has mask zeroing the 2 B fields; PHV metadata[4:0]=3 → 2 B key bits = 0, other fields unchanged. PHV addressing entry 31 that was never written → key_out=0.
- **Collision:** in the same cycle, write entry 0 (swapping 6↔7) and send a PHV addressed to entry 0 → that PHV uses the old key. The next PHV to entry 0 uses the new key.
- **Streaming and reset mid-stream:** 4 back-to-back PHVs alternating entries 0/3 → 4 consecutive valid outputs, each with the correct key. Assert rst with 2 PHVs in flight → neither emits a valid after release.

Source files
------------

// File: rtl/key_extract_param_if.sv
// rtl/key_extract_param_if.sv - PHV/key/config bundle for the key extractor
//
// Purpose: groups the PHV input stream, the offset-table write port and the
// PHV/key output stream of key_extract_param into one bundle.
//
// Signals:
//   phv_in        PHV presented to the stage
//   phv_valid_in  one-cycle qualifier per PHV
//   cfg_wr_en     offset-table write strobe
//   cfg_addr      offset-table write address
//   cfg_data      offset-table write data (one entry)
//   phv_out       PHV delayed by the stage pipeline
//   phv_valid_out qualifier for phv_out
//   key_out       masked lookup key
//   key_valid_out qualifier for key_out (tracks phv_valid_out)
//
// Modports:
//   master  upstream side (drives PHV and config, observes results)
//   slave   the extractor itself

interface key_extract_param_if #(
  parameter int PHV_LEN = 1024,
  parameter int KEY_LEN = 193,
  parameter int ENT_LEN = 219,
  parameter int TBL_AW  = 5
);

  logic [PHV_LEN-1:0] phv_in;
  logic               phv_valid_in;
  logic               cfg_wr_en;
  logic [TBL_AW-1:0]  cfg_addr;
  logic [ENT_LEN-1:0] cfg_data;
  logic [PHV_LEN-1:0] phv_out;
  logic               phv_valid_out;
  logic [KEY_LEN-1:0] key_out;
  logic               key_valid_out;

  modport master (
    output phv_in, phv_valid_in, cfg_wr_en, cfg_addr, cfg_data,
    input  phv_out, phv_valid_out, key_out, key_valid_out
  );

  modport slave (
    input  phv_in, phv_valid_in, cfg_wr_en, cfg_addr, cfg_data,
    output phv_out, phv_valid_out, key_out, key_valid_out
  );

endinterface

// File: rtl/key_extract_param.sv
// rtl/key_extract_param.sv - parametrised RMT match-stage key extractor
//
// Purpose: looks up an offset/mask/compare entry selected by the PHV metadata
// LSBs, gathers KEY_N containers from each width class (6 B, 4 B, 2 B) plus
// one comparator bit into a key, masks it, and forwards the PHV alongside.
// Two-cycle latency, one PHV per clock, no backpressure.
//
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset; clears table and pipeline
//   bus  key_extract_param_if.slave
//        in : phv_in, phv_valid_in, cfg_wr_en, cfg_addr, cfg_data
//        out: phv_out, phv_valid_out, key_out, key_valid_out
//
// PHV layout (MSB first): 6 B containers [C_NUM-1..0], 4 B containers,
// 2 B containers, metadata. Entry layout (MSB first): 6 B indices (field 0
// first), 4 B indices, 2 B indices, cmp_op, cmp_a, cmp_b, mask.
// Key layout (MSB first): 6 B picks, 4 B picks, 2 B picks, cmp_bit.

module key_extract_param #(
  parameter int C_NUM     = 8,
  parameter int IDX_W     = 3,
  parameter int KEY_N     = 2,
  parameter int META_LEN  = 256,
  parameter int TBL_DEPTH = 32,
  parameter int TBL_AW    = 5,
  parameter int PHV_LEN   = C_NUM*96 + META_LEN,
  parameter int KEY_LEN   = KEY_N*96 + 1,
  parameter int ENT_LEN   = 3*KEY_N*IDX_W + 2 + 2*IDX_W + KEY_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  key_extract_param_if.slave     bus
);

  localparam int W6 = 48;
  localparam int W4 = 32;
  localparam int W2 = 16;

  // Container base offsets inside the PHV
  localparam int OFF2 = META_LEN;
  localparam int OFF4 = OFF2 + C_NUM*W2;
  localparam int OFF6 = OFF4 + C_NUM*W4;

  // Field offsets inside a table entry
  localparam int CMPB_LSB = KEY_LEN;
  localparam int CMPA_LSB = CMPB_LSB + IDX_W;
  localparam int OP_LSB   = CMPA_LSB + IDX_W;
  localparam int IDX2_LSB = OP_LSB + 2;
  localparam int IDX4_LSB = IDX2_LSB + KEY_N*IDX_W;
  localparam int IDX6_LSB = IDX4_LSB + KEY_N*IDX_W;

  // Group offsets inside the key; bit 0 is the comparator result
  localparam int KEY2_LSB = 1;
  localparam int KEY4_LSB = KEY2_LSB + KEY_N*W2;
  localparam int KEY6_LSB = KEY4_LSB + KEY_N*W4;

  // ---------------------------------------------------------------------
  // Container pickers
  // ---------------------------------------------------------------------
  function automatic logic [W6-1:0] pick6(input logic [PHV_LEN-1:0] p,
                                          input logic [IDX_W-1:0]   i);
    return p[OFF6 + W6*int'(i) +: W6];
  endfunction

  function automatic logic [W4-1:0] pick4(input logic [PHV_LEN-1:0] p,
                                          input logic [IDX_W-1:0]   i);
    return p[OFF4 + W4*int'(i) +: W4];
  endfunction

  function automatic logic [W2-1:0] pick2(input logic [PHV_LEN-1:0] p,
                                          input logic [IDX_W-1:0]   i);
    return p[OFF2 + W2*int'(i) +: W2];
  endfunction

  // ---------------------------------------------------------------------
  // Address range qualification
  // ---------------------------------------------------------------------
  // When the table fills the whole address space every address is legal, so
  // the range compare is only built for a partially populated table.
  logic [TBL_AW-1:0] rd_addr;
  logic              wr_ok;
  logic              rd_ok;

  assign rd_addr = bus.phv_in[TBL_AW-1:0];

  generate
    if (TBL_DEPTH >= (1 << TBL_AW)) begin : g_full_tbl
      assign wr_ok = 1'b1;
      assign rd_ok = 1'b1;
    end else begin : g_part_tbl
      assign wr_ok = ({1'b0, bus.cfg_addr} < (TBL_AW+1)'(TBL_DEPTH));
      assign rd_ok = ({1'b0, rd_addr}      < (TBL_AW+1)'(TBL_DEPTH));
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Offset table: one write port, one registered read port
  // ---------------------------------------------------------------------
  logic [ENT_LEN-1:0] tbl [TBL_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TBL_DEPTH; i++) begin
        tbl[i] <= '0;
      end
    end else if (bus.cfg_wr_en && wr_ok) begin
      tbl[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: capture PHV, valid and the addressed entry.
  // The read samples tbl before this edge's write lands, so a same-cycle
  // write/lookup to one address returns the old entry.
  // ---------------------------------------------------------------------
  logic [PHV_LEN-1:0] s1_phv;
  logic               s1_valid;
  logic [ENT_LEN-1:0] s1_ent;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_phv   <= '0;
      s1_valid <= 1'b0;
      s1_ent   <= '0;
    end else begin
      s1_phv   <= bus.phv_in;
      s1_valid <= bus.phv_valid_in;
      s1_ent   <= rd_ok ? tbl[rd_addr] : '0;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2 combinational: container mux, comparator, mask
  // ---------------------------------------------------------------------
  logic [1:0]         cmp_op;
  logic [IDX_W-1:0]   cmp_a;
  logic [IDX_W-1:0]   cmp_b;
  logic [W4-1:0]      opnd_a;
  logic [W4-1:0]      opnd_b;
  logic               cmp_bit;
  logic [KEY_LEN-1:0] raw_key;
  logic [KEY_LEN-1:0] masked_key;

  assign cmp_op = s1_ent[OP_LSB   +: 2];
  assign cmp_a  = s1_ent[CMPA_LSB +: IDX_W];
  assign cmp_b  = s1_ent[CMPB_LSB +: IDX_W];
  assign opnd_a = pick4(s1_phv, cmp_a);
  assign opnd_b = pick4(s1_phv, cmp_b);

  always_comb begin
    cmp_bit = 1'b0;
    unique case (cmp_op)
      2'b00: cmp_bit = 1'b0;
      2'b01: cmp_bit = (opnd_a == opnd_b);
      2'b10: cmp_bit = (opnd_a >  opnd_b);
      2'b11: cmp_bit = (opnd_a >= opnd_b);
      default: cmp_bit = 1'b0;
    endcase
  end

  // Field 0 of each group lands in the most significant slot of that group.
  always_comb begin
    raw_key    = '0;
    raw_key[0] = cmp_bit;
    for (int k = 0; k < KEY_N; k++) begin
      raw_key[KEY6_LSB + (KEY_N-1-k)*W6 +: W6] =
        pick6(s1_phv, s1_ent[IDX6_LSB + (KEY_N-1-k)*IDX_W +: IDX_W]);
      raw_key[KEY4_LSB + (KEY_N-1-k)*W4 +: W4] =
        pick4(s1_phv, s1_ent[IDX4_LSB + (KEY_N-1-k)*IDX_W +: IDX_W]);
      raw_key[KEY2_LSB + (KEY_N-1-k)*W2 +: W2] =
        pick2(s1_phv, s1_ent[IDX2_LSB + (KEY_N-1-k)*IDX_W +: IDX_W]);
    end
  end

  assign masked_key = raw_key & s1_ent[KEY_LEN-1:0];

  // ---------------------------------------------------------------------
  // Stage 2 registers
  // ---------------------------------------------------------------------
  logic [PHV_LEN-1:0] s2_phv;
  logic [KEY_LEN-1:0] s2_key;
  logic               s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_phv   <= '0;
      s2_key   <= '0;
      s2_valid <= 1'b0;
    end else begin
      s2_phv   <= s1_phv;
      s2_key   <= masked_key;
      s2_valid <= s1_valid;
    end
  end

  assign bus.phv_out       = s2_phv;
  assign bus.phv_valid_out = s2_valid;
  assign bus.key_out       = s2_key;
  assign bus.key_valid_out = s2_valid;

endmodule

// File: tb/tb_key_extract_param.sv
// tb/tb_key_extract_param.sv - self-checking bench for key_extract_param

module tb_key_extract_param;

  localparam int PL = 1024;
  localparam int KL = 193;
  localparam int EL = 219;

  logic clk;
  logic rst;

  key_extract_param_if #(.PHV_LEN(PL), .KEY_LEN(KL), .ENT_LEN(EL), .TBL_AW(5)) bus ();

  key_extract_param dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference table and a two-deep expectation pipe
  logic [EL-1:0] mtbl [32];
  bit            p0v, p1v;
  logic [KL-1:0] p0k, p1k;
  logic [PL-1:0] p0p, p1p;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [PL-1:0] put6(input logic [PL-1:0] p, input int i, input logic [47:0] v);
    p[256 + 384 + 48*i +: 48] = v;
    return p;
  endfunction
  function automatic logic [PL-1:0] put4(input logic [PL-1:0] p, input int i, input logic [31:0] v);
    p[256 + 128 + 32*i +: 32] = v;
    return p;
  endfunction
  function automatic logic [PL-1:0] put2(input logic [PL-1:0] p, input int i, input logic [15:0] v);
    p[256 + 16*i +: 16] = v;
    return p;
  endfunction

  function automatic logic [EL-1:0] mk_entry(
      input logic [2:0] i60, input logic [2:0] i61, input logic [2:0] i40, input logic [2:0] i41,
      input logic [2:0] i20, input logic [2:0] i21, input logic [1:0] op,
      input logic [2:0] a, input logic [2:0] b, input logic [KL-1:0] m);
    return {i60, i61, i40, i41, i20, i21, op, a, b, m};
  endfunction

  // Reference key: unpack containers and entry fields, concatenate picks.
  function automatic logic [KL-1:0] ref_key(input logic [PL-1:0] p, input logic [EL-1:0] e);
    logic [47:0]   c6 [8];
    logic [31:0]   c4 [8];
    logic [15:0]   c2 [8];
    logic [2:0]    i6 [2];
    logic [2:0]    i4 [2];
    logic [2:0]    i2 [2];
    logic [EL-1:0] t;
    logic [KL-1:0] m, raw;
    logic [2:0]    ca, cb;
    logic [1:0]    op;
    logic          cbit;
    for (int i = 0; i < 8; i++) begin
      c2[i] = p[256 + 16*i +: 16];
      c4[i] = p[384 + 32*i +: 32];
      c6[i] = p[640 + 48*i +: 48];
    end
    t = e;
    m = t[KL-1:0]; t = t >> KL;
    cb = t[2:0];   t = t >> 3;
    ca = t[2:0];   t = t >> 3;
    op = t[1:0];   t = t >> 2;
    i2[1] = t[2:0]; t = t >> 3;
    i2[0] = t[2:0]; t = t >> 3;
    i4[1] = t[2:0]; t = t >> 3;
    i4[0] = t[2:0]; t = t >> 3;
    i6[1] = t[2:0]; t = t >> 3;
    i6[0] = t[2:0];
    case (op)
      2'd1:    cbit = (c4[ca] == c4[cb]);
      2'd2:    cbit = (c4[ca] >  c4[cb]);
      2'd3:    cbit = (c4[ca] >= c4[cb]);
      default: cbit = 1'b0;
    endcase
    raw = '0;
    for (int k = 0; k < 2; k++) raw = (raw << 48) | KL'(c6[i6[k]]);
    for (int k = 0; k < 2; k++) raw = (raw << 32) | KL'(c4[i4[k]]);
    for (int k = 0; k < 2; k++) raw = (raw << 16) | KL'(c2[i2[k]]);
    raw = (raw << 1) | KL'(cbit);
    return raw & m;
  endfunction

  function automatic logic [PL-1:0] rand_phv(input logic [4:0] addr);
    logic [PL-1:0] p;
    for (int i = 0; i < PL/32; i++) p[i*32 +: 32] = $urandom;
    p[4:0] = addr;
    return p;
  endfunction

  function automatic logic [EL-1:0] rand_ent();
    logic [EL-1:0] e;
    e = '0;
    for (int i = 0; i < 7; i++) e = (e << 32) | EL'($urandom);
    return e;
  endfunction

  // One clock: drive inputs, advance the model, clock, check outputs.
  task automatic step(input bit v, input logic [PL-1:0] p, input bit we,
                      input logic [4:0] wa, input logic [EL-1:0] wd);
    bus.phv_valid_in = v;
    bus.phv_in       = p;
    bus.cfg_wr_en    = we;
    bus.cfg_addr     = wa;
    bus.cfg_data     = wd;
    if (rst) begin
      for (int i = 0; i < 32; i++) mtbl[i] = '0;
      p0v = 1'b0;
      p1v = 1'b0;
    end
    p1v = p0v; p1k = p0k; p1p = p0p;
    p0v = v && !rst;
    p0p = p;
    p0k = ref_key(p, mtbl[p[4:0]]);
    if (we && !rst) mtbl[wa] = wd;
    @(posedge clk);
    @(negedge clk);
    chk("phv_valid", 512'(bus.phv_valid_out), 512'(p1v));
    chk("key_valid", 512'(bus.key_valid_out), 512'(p1v));
    if (p1v) begin
      chk("key", 512'(bus.key_out), 512'(p1k));
      chk("phv_hi", bus.phv_out[1023:512], p1p[1023:512]);
      chk("phv_lo", bus.phv_out[511:0], p1p[511:0]);
    end
  endtask

  task automatic idle();
    step(1'b0, rand_phv(5'd0), 1'b0, 5'd0, '0);
  endtask

  logic [PL-1:0] sp, ep, rp;
  logic [KL-1:0] ones, m3, swap_key, new_key, obs_k;
  logic [4:0]    a;

  initial begin
    for (int i = 0; i < 32; i++) mtbl[i] = '0;
    p0v = 0; p1v = 0; p0k = '0; p1k = '0; p0p = '0; p1p = '0;
    rst = 1'b1;
    bus.phv_valid_in = 1'b0;
    bus.phv_in = '0;
    bus.cfg_wr_en = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    ones = '1;
    swap_key = {48'heeeeeeeeeeee, 48'hffffffffffff, 32'hbbbbbbbb, 32'hcccccccc,
                16'heeee, 16'hffff, 1'b0};
    new_key  = {48'hffffffffffff, 48'heeeeeeeeeeee, 32'hcccccccc, 32'hbbbbbbbb,
                16'hffff, 16'heeee, 1'b0};
    sp = '0;
    sp = put6(sp, 7, 48'hffffffffffff); sp = put6(sp, 6, 48'heeeeeeeeeeee);
    sp = put4(sp, 7, 32'hcccccccc);     sp = put4(sp, 6, 32'hbbbbbbbb);
    sp = put2(sp, 7, 16'hffff);         sp = put2(sp, 6, 16'heeee);
    @(negedge clk);

    // Reset held with valid PHVs presented
    for (int i = 0; i < 3; i++) begin
      step(1'b1, rand_phv(5'($urandom_range(0, 31))), 1'b0, 5'd0, '0);
      chk("rst_key", 512'(bus.key_out), 512'(0));
      chk("rst_phv", bus.phv_out[511:0], 512'(0));
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, rand_phv(5'd0), 1'b0, 5'd0, '0);
      chk("post_rst_key", 512'(bus.key_out), 512'(0));
    end

    // Container swap on entry 0
    step(1'b0, '0, 1'b1, 5'd0, mk_entry(6, 7, 6, 7, 6, 7, 2'd0, 0, 0, ones));
    step(1'b1, sp, 1'b0, 5'd0, '0);
    idle();
    chk("swap_key", 512'(bus.key_out), 512'(swap_key));
    chk("swap_phv", bus.phv_out[1023:512], sp[1023:512]);

    // Comparator ops on entries 1,2,4,5
    step(1'b0, '0, 1'b1, 5'd1, mk_entry(6, 7, 6, 7, 6, 7, 2'd2, 7, 6, ones));
    step(1'b0, '0, 1'b1, 5'd2, mk_entry(6, 7, 6, 7, 6, 7, 2'd1, 7, 6, ones));
    step(1'b0, '0, 1'b1, 5'd4, mk_entry(6, 7, 6, 7, 6, 7, 2'd3, 7, 6, ones));
    step(1'b0, '0, 1'b1, 5'd5, mk_entry(6, 7, 6, 7, 6, 7, 2'd0, 7, 6, ones));
    ep = sp; ep[4:0] = 5'd1;
    step(1'b1, ep, 1'b0, 5'd0, '0); idle();
    chk("cmp_gt", 512'(bus.key_out[0]), 512'(1));
    ep[4:0] = 5'd2;
    step(1'b1, ep, 1'b0, 5'd0, '0); idle();
    chk("cmp_eq", 512'(bus.key_out[0]), 512'(0));
    ep = put4(sp, 6, 32'hcccccccc); ep[4:0] = 5'd4;
    step(1'b1, ep, 1'b0, 5'd0, '0); idle();
    chk("cmp_ge_equal", 512'(bus.key_out[0]), 512'(1));
    ep = sp; ep[4:0] = 5'd5;
    step(1'b1, ep, 1'b0, 5'd0, '0); idle();
    chk("cmp_off", 512'(bus.key_out[0]), 512'(0));

    // Mask on entry 3 and unwritten entry 31
    m3 = ones; m3[32:1] = '0;
    step(1'b0, '0, 1'b1, 5'd3, mk_entry(6, 7, 6, 7, 6, 7, 2'd0, 0, 0, m3));
    ep = sp; ep[4:0] = 5'd3;
    step(1'b1, ep, 1'b0, 5'd0, '0); idle();
    obs_k = bus.key_out;
    chk("mask_2b", 512'(obs_k[32:1]), 512'(0));
    chk("mask_rest", 512'(obs_k[192:33]), 512'(swap_key[192:33]));
    ep = sp; ep[4:0] = 5'd31;
    step(1'b1, ep, 1'b0, 5'd0, '0); idle();
    chk("unwritten", 512'(bus.key_out), 512'(0));

    // Write/lookup collision on entry 0
    step(1'b1, sp, 1'b1, 5'd0, mk_entry(7, 6, 7, 6, 7, 6, 2'd0, 0, 0, ones));
    idle();
    chk("collide_old", 512'(bus.key_out), 512'(swap_key));
    step(1'b1, sp, 1'b0, 5'd0, '0); idle();
    chk("collide_new", 512'(bus.key_out), 512'(new_key));

    // Back-to-back alternating entries 0/3
    for (int i = 0; i < 4; i++) step(1'b1, rand_phv((i % 2) ? 5'd3 : 5'd0), 1'b0, 5'd0, '0);
    idle(); idle();

    // Randomized traffic with interleaved table writes
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      step(($urandom_range(0, 3) != 0), rand_phv(a),
           ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)), rand_ent());
    end
    idle(); idle();

    // Reset with PHVs in flight
    step(1'b1, rand_phv(5'd0), 1'b0, 5'd0, '0);
    rst = 1'b1;
    step(1'b1, rand_phv(5'd3), 1'b0, 5'd0, '0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) idle();
    step(1'b1, sp, 1'b0, 5'd0, '0); idle();
    chk("cleared_tbl", 512'(bus.key_out), 512'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
